// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_pkg
// Description : Shared raster timing definition for the 640x480@60 VGA path.
//               Holds the default H/V porch and sync widths, the derived
//               totals and sync window bounds, and the overlay transparency
//               code. The timing source and every overlay generator import
//               this, so they all work from one timing definition.
// Contents    : c_coord_w, coord_t          - raster coordinate width/type
//               c_h_* / c_v_*               - default horizontal/vertical timing
//               c_hs_* / c_vs_*             - sync window bounds (end exclusive)
//               c_color_transparent         - "no pixel" code for overlays
//               sync_level()                - map "inside sync window" to pin level
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_gen_pkg;

    localparam int c_coord_w = 10;
    typedef logic [c_coord_w-1:0] coord_t;

    // Horizontal timing, in pixels
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

    // Vertical timing, in lines
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    // Sync windows: first asserted count, and first count past the pulse
    localparam int c_hs_start = c_h_active + c_h_fp;
    localparam int c_hs_end   = c_hs_start + c_h_sync;
    localparam int c_vs_start = c_v_active + c_v_fp;
    localparam int c_vs_end   = c_vs_start + c_v_sync;

    // Colour code an overlay drives when it has nothing to draw
    localparam logic [7:0] c_color_transparent = 8'hE3;

    // Pin level for a sync output: the asserted polarity inside the window,
    // its complement outside.
    function automatic logic sync_level(input logic in_window, input logic pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Enabled up-counter that runs 0..MAX and wraps back to 0.
//               Used for both raster axes of vga_timing_gen.
// Ports       : clk   in   clock
//               rst_n in   synchronous reset, active-low (count -> 0)
//               en    in   advance enable
//               cnt   out  current count (registered)
//               wrap  out  high when en is high and cnt == MAX, i.e. on the
//                          cycle whose clock edge returns the count to 0
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int MAX   = 799,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == c_max);
    assign wrap     = en && w_at_max;
    assign cnt      = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Free-running raster timing source for the VGA path. Counts
//               x/y under pixel-enable, produces registered hsync/vsync that
//               change on the same edge as x/y, and combinational active,
//               frame_start and line_end qualified by the current x/y.
// Ports       : clk         in   1   system/pixel clock
//               rst_n       in   1   synchronous reset, active-low
//               pix_en      in   1   pixel tick; counters advance when high
//               x           out  10  horizontal count 0..H_TOTAL-1
//               y           out  10  vertical count 0..V_TOTAL-1
//               active      out  1   x < H_ACTIVE && y < V_ACTIVE
//               hsync       out  1   horizontal sync, SYNC_POL when asserted
//               vsync       out  1   vertical sync, SYNC_POL when asserted
//               frame_start out  1   pix_en && x == 0 && y == 0
//               line_end    out  1   pix_en && x == H_TOTAL-1
//               frame_cnt   out  8   frames completed, wraps 255 -> 0
// Config      : VGA_FRAME_COUNTER_EN - when defined, adds frame_cnt and its
//               register; otherwise the port is absent.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = c_h_active,
    parameter int   H_FP     = c_h_fp,
    parameter int   H_SYNC   = c_h_sync,
    parameter int   H_BP     = c_h_bp,
    parameter int   V_ACTIVE = c_v_active,
    parameter int   V_FP     = c_v_fp,
    parameter int   V_SYNC   = c_v_sync,
    parameter int   V_BP     = c_v_bp,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_en,
    output coord_t       x,
    output coord_t       y,
    output logic         active,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_start,
    output logic         line_end
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [7:0]   frame_cnt
`endif
);

    localparam int     c_x_total     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     c_y_total     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t c_x_act_end   = coord_t'(H_ACTIVE);
    localparam coord_t c_y_act_end   = coord_t'(V_ACTIVE);
    localparam coord_t c_x_sync_beg  = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t c_x_sync_end  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t c_y_sync_beg  = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t c_y_sync_end  = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic   w_h_wrap;
    logic   w_v_wrap;
    logic   w_v_en;
    coord_t w_x_next;
    coord_t w_y_next;
    logic   w_hs_win;
    logic   w_vs_win;
    logic   r_hsync;
    logic   r_vsync;

    // ------------------------------------------------------------------------
    // Raster counters: the vertical counter steps once per horizontal wrap,
    // so its own wrap marks the (H_TOTAL-1, V_TOTAL-1) -> (0,0) edge.
    // ------------------------------------------------------------------------
    wrap_counter #(
        .MAX   (c_x_total - 1),
        .WIDTH (c_coord_w)
    ) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .cnt   (x),
        .wrap  (w_h_wrap)
    );

    assign w_v_en = pix_en && w_h_wrap;

    wrap_counter #(
        .MAX   (c_y_total - 1),
        .WIDTH (c_coord_w)
    ) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_v_en),
        .cnt   (y),
        .wrap  (w_v_wrap)
    );

    // ------------------------------------------------------------------------
    // Sync decode. The registers look at the value each counter is about to
    // take, so the sync pins move on exactly the edge that x/y move and line
    // up with the same-cycle x/y seen by the overlay mux.
    // ------------------------------------------------------------------------
    assign w_x_next = w_h_wrap ? '0 : x + 1'b1;
    assign w_y_next = w_v_wrap ? '0 : y + 1'b1;

    assign w_hs_win = (w_x_next >= c_x_sync_beg) && (w_x_next < c_x_sync_end);
    assign w_vs_win = (w_y_next >= c_y_sync_beg) && (w_y_next < c_y_sync_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else begin
            if (pix_en) begin
                r_hsync <= sync_level(w_hs_win, SYNC_POL);
            end
            // y only changes at a line wrap, so vsync is updated only there
            if (w_v_en) begin
                r_vsync <= sync_level(w_vs_win, SYNC_POL);
            end
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;

    // ------------------------------------------------------------------------
    // Markers: combinational from the registered counters, gated by rst_n so
    // nothing downstream sees a displayable pixel or a pulse during reset.
    // ------------------------------------------------------------------------
    assign active      = rst_n && (x < c_x_act_end) && (y < c_y_act_end);
    assign frame_start = rst_n && pix_en && (x == '0) && (y == '0);
    assign line_end    = rst_n && w_h_wrap;

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Two instances share
//               one stimulus stream: one with the standard 640x480 timing and
//               one with a tiny raster so frame-level behaviour fits in a
//               short run. A position model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    // Tiny raster: 16 x 8, hsync at x=10..13, vsync at y=5..6
    localparam int S_HA = 8;
    localparam int S_HFP = 2;
    localparam int S_HS = 4;
    localparam int S_HBP = 2;
    localparam int S_VA = 4;
    localparam int S_VFP = 1;
    localparam int S_VS = 2;
    localparam int S_VBP = 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       frame_start;
        logic       line_end;
        logic [7:0] frame_cnt;
    } obs_t;

    typedef struct { int x; int y; int fc; } mstate_t;
    typedef struct { int ha; int hfp; int hs; int hbp; int va; int vfp; int vs; int vbp; } geo_t;
    typedef struct { bit r; bit p; int x; int y; bit act; bit hs; bit vs; bit fs; bit le; } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    logic [9:0] def_x, def_y, sm_x, sm_y;
    logic def_act, def_hs, def_vs, def_fs, def_le;
    logic sm_act, sm_hs, sm_vs, sm_fs, sm_le;
    logic [7:0] def_fc, sm_fc;

    int n_checks = 0;
    int n_pass   = 0;

    geo_t    g_def, g_sm;
    mstate_t m_def, m_sm;
    obs_t    q_def[$];
    obs_t    q_sm[$];
    obs_t    o_def, o_sm;

    always #5 clk = ~clk;

`ifndef VGA_FRAME_COUNTER_EN
    assign def_fc = 8'd0;
    assign sm_fc  = 8'd0;
`endif

    vga_timing_gen u_def (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .x           (def_x),
        .y           (def_y),
        .active      (def_act),
        .hsync       (def_hs),
        .vsync       (def_vs),
        .frame_start (def_fs),
        .line_end    (def_le)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_cnt   (def_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .SYNC_POL (1'b0)
    ) u_sm (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .x           (sm_x),
        .y           (sm_y),
        .active      (sm_act),
        .hsync       (sm_hs),
        .vsync       (sm_vs),
        .frame_start (sm_fs),
        .line_end    (sm_le)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_cnt   (sm_fc)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outputs for the raster position held in m, under inputs r/p
    function automatic obs_t model_out(mstate_t m, bit r, bit p, geo_t g);
        obs_t o;
        int ht = g.ha + g.hfp + g.hs + g.hbp;
        o.x           = 10'(m.x);
        o.y           = 10'(m.y);
        o.active      = r && (m.x < g.ha) && (m.y < g.va);
        o.hsync       = !((m.x >= g.ha + g.hfp) && (m.x < g.ha + g.hfp + g.hs));
        o.vsync       = !((m.y >= g.va + g.vfp) && (m.y < g.va + g.vfp + g.vs));
        o.frame_start = r && p && (m.x == 0) && (m.y == 0);
        o.line_end    = r && p && (m.x == ht - 1);
`ifdef VGA_FRAME_COUNTER_EN
        o.frame_cnt   = 8'(m.fc);
`else
        o.frame_cnt   = 8'd0;
`endif
        return o;
    endfunction

    function automatic mstate_t model_step(mstate_t m, bit r, bit p, geo_t g);
        mstate_t n = m;
        int ht = g.ha + g.hfp + g.hs + g.hbp;
        int vt = g.va + g.vfp + g.vs + g.vbp;
        if (!r) begin
            n.x = 0; n.y = 0; n.fc = 0;
        end else if (p) begin
            if (m.x == ht - 1) begin
                n.x = 0;
                if (m.y == vt - 1) begin
                    n.y  = 0;
                    n.fc = (m.fc + 1) % 256;
                end else begin
                    n.y = m.y + 1;
                end
            end else begin
                n.x = m.x + 1;
            end
        end
        return n;
    endfunction

    function automatic obs_t cur_def();
        return {def_x, def_y, def_act, def_hs, def_vs, def_fs, def_le, def_fc};
    endfunction

    function automatic obs_t cur_sm();
        return {sm_x, sm_y, sm_act, sm_hs, sm_vs, sm_fs, sm_le, sm_fc};
    endfunction

    // Scoreboard: one expectation per driven cycle, compared mid-cycle
    always @(negedge clk) begin : sb_monitor
        obs_t e;
        if (q_def.size() != 0) begin
            e = q_def.pop_front();
            check("sb_default", 64'(cur_def()), 64'(e));
        end
        if (q_sm.size() != 0) begin
            e = q_sm.pop_front();
            check("sb_small", 64'(cur_sm()), 64'(e));
        end
    end

    // Drive one cycle: inputs set just after a rising edge, outputs captured
    // on the falling edge, model advanced on the next rising edge.
    task automatic tick(input bit r, input bit p);
        rst_n  = r;
        pix_en = p;
        q_def.push_back(model_out(m_def, r, p, g_def));
        q_sm.push_back(model_out(m_sm, r, p, g_sm));
        @(negedge clk);
        o_def = cur_def();
        o_sm  = cur_sm();
        @(posedge clk);
        m_def = model_step(m_def, r, p, g_def);
        m_sm  = model_step(m_sm, r, p, g_sm);
        #1;
    endtask

    initial begin
        vec_t vecs[11];
        int   hs_cnt, hs_first, hs_last, first_idle, le_cnt, le_x, vs_low, idle_pulses, fs_cnt;
        int   fs_tick[$];
        bit   found;

        g_def = '{640, 16, 96, 48, 480, 10, 2, 33};
        g_sm  = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};
        m_def = '{0, 0, 0};
        m_sm  = '{0, 0, 0};

        //            r  p  x  y  act hs vs fs le
        vecs[0]  = '{0, 1, 0, 0, 0,  1, 1, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0,  1, 1, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0,  1, 1, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0,  1, 1, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0,  1, 1, 0, 0};
        vecs[5]  = '{1, 1, 0, 0, 1,  1, 1, 1, 0};
        vecs[6]  = '{1, 1, 1, 0, 1,  1, 1, 0, 0};
        vecs[7]  = '{1, 0, 2, 0, 1,  1, 1, 0, 0};
        vecs[8]  = '{1, 0, 2, 0, 1,  1, 1, 0, 0};
        vecs[9]  = '{1, 1, 2, 0, 1,  1, 1, 0, 0};
        vecs[10] = '{1, 1, 3, 0, 1,  1, 1, 0, 0};

        rst_n  = 1'b0;
        pix_en = 1'b1;
        @(posedge clk);
        #1;

        // Reset hold, release, and pix_en hold on the standard raster
        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].r, vecs[i].p);
            check($sformatf("vec%0d", i),
                  {o_def.x, o_def.y, o_def.active, o_def.hsync, o_def.vsync, o_def.frame_start, o_def.line_end},
                  {10'(vecs[i].x), 10'(vecs[i].y), vecs[i].act, vecs[i].hs, vecs[i].vs, vecs[i].fs, vecs[i].le});
        end

        // Rest of line 0: x = 4..799
        hs_cnt = 0; hs_first = -1; hs_last = -1; first_idle = -1; le_cnt = 0; le_x = -1;
        for (int i = 0; i < 796; i++) begin
            tick(1, 1);
            if (!o_def.hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(o_def.x);
                hs_last = int'(o_def.x);
            end
            if (!o_def.active && first_idle < 0) first_idle = int'(o_def.x);
            if (o_def.line_end) begin
                le_cnt++;
                le_x = int'(o_def.x);
            end
        end
        check("hsync_width", 64'(hs_cnt), 64'd96);
        check("hsync_first_x", 64'(hs_first), 64'd656);
        check("hsync_last_x", 64'(hs_last), 64'd751);
        check("active_end_x", 64'(first_idle), 64'd640);
        check("line_end_count", 64'(le_cnt), 64'd1);
        check("line_end_x", 64'(le_x), 64'd799);
        tick(1, 1);
        check("line1_xy", {o_def.x, o_def.y}, {10'd0, 10'd1});

        // Full frames on the tiny raster
        vs_low = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1, 1);
            if (o_sm.frame_start) fs_tick.push_back(i);
            if (fs_tick.size() == 1 && !o_sm.vsync) vs_low++;
        end
        check("frame_pulses", 64'(fs_tick.size() >= 3), 64'd1);
        if (fs_tick.size() >= 3) begin
            check("frame_period_a", 64'(fs_tick[1] - fs_tick[0]), 64'd128);
            check("frame_period_b", 64'(fs_tick[2] - fs_tick[1]), 64'd128);
        end
        check("vsync_cycles", 64'(vs_low), 64'd32);

        // Half-rate pixel enable
        fs_tick.delete();
        idle_pulses = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(1, (i % 2) == 0);
            if (o_sm.frame_start) fs_tick.push_back(i);
            if ((i % 2) != 0 && (o_sm.frame_start || o_sm.line_end || o_def.frame_start || o_def.line_end))
                idle_pulses++;
        end
        check("half_rate_pulses", 64'(fs_tick.size() >= 3), 64'd1);
        if (fs_tick.size() >= 3) begin
            check("half_rate_period_a", 64'(fs_tick[1] - fs_tick[0]), 64'd256);
            check("half_rate_period_b", 64'(fs_tick[2] - fs_tick[1]), 64'd256);
        end
        check("no_pulse_when_idle", 64'(idle_pulses), 64'd0);

        // Reset in the middle of both sync pulses on the tiny raster
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick(1, 1);
            if (o_sm.x == 10'd11 && o_sm.y == 10'd6) found = 1'b1;
        end
        check("reach_small_sync", 64'(found), 64'd1);
        tick(0, 1);
        check("small_in_sync", {o_sm.hsync, o_sm.vsync}, 2'b00);
        tick(1, 1);
        check("small_after_rst", {o_sm.x, o_sm.y, o_sm.hsync, o_sm.vsync}, {10'd0, 10'd0, 2'b11});

        // Reset in the middle of hsync on the standard raster
        found = 1'b0;
        for (int i = 0; i < 900 && !found; i++) begin
            tick(1, 1);
            if (o_def.x == 10'd699) found = 1'b1;
        end
        check("reach_x699", 64'(found), 64'd1);
        tick(0, 1);
        check("def_in_hsync", {o_def.x, o_def.hsync}, {10'd700, 1'b0});
        tick(1, 1);
        check("def_after_rst", {o_def.x, o_def.y, o_def.hsync, o_def.vsync, o_def.active}, {10'd0, 10'd0, 3'b111});

        // 257 tiny frames from reset: counter wraps 255 -> 0 -> 1
        tick(0, 1);
        fs_cnt = 0;
        for (int j = 0; j <= 257 * 128; j++) begin
            tick(1, 1);
            if (o_sm.frame_start) fs_cnt++;
`ifdef VGA_FRAME_COUNTER_EN
            if (j == 128)       check("frame_cnt_1", 64'(o_sm.frame_cnt), 64'd1);
            if (j == 255 * 128) check("frame_cnt_255", 64'(o_sm.frame_cnt), 64'd255);
            if (j == 256 * 128) check("frame_cnt_wrap", 64'(o_sm.frame_cnt), 64'd0);
            if (j == 257 * 128) check("frame_cnt_after_wrap", 64'(o_sm.frame_cnt), 64'd1);
`endif
        end
        check("frame_start_count", 64'(fs_cnt), 64'd258);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
